// File: rtl/scr1_rst_seq_pkg.sv
// -----------------------------------------------------------------------------
// scr1_rst_seq_pkg
// Shared types and helpers for the reset sequencer:
//   type_scr1_rst_seq_state_e : per-channel release state (HOLD, COUNT, RUN)
//   SCR1_RST_SEQ_SYNC_MIN     : minimum synchronizer depth
//   scr1_rst_seq_cnt_w()      : width of the release-delay counter
// -----------------------------------------------------------------------------
package scr1_rst_seq_pkg;

   typedef enum logic [1:0] {
      HOLD  = 2'd0,
      COUNT = 2'd1,
      RUN   = 2'd2
   } type_scr1_rst_seq_state_e;

   localparam int SCR1_RST_SEQ_SYNC_MIN = 2;

   // Counter must hold 0..RELEASE_DLY-1; keep at least one bit so a zero
   // delay still yields a legal vector.
   function automatic int scr1_rst_seq_cnt_w(input int dly);
      int w;
      w = $clog2(dly + 1);
      return (w < 1) ? 1 : w;
   endfunction

endpackage

// File: rtl/scr1_rst_sync_cell.sv
// -----------------------------------------------------------------------------
// scr1_rst_sync_cell
// One reset-request synchronizer: din passes through SYNC_STAGES flops,
// all cleared asynchronously by rst_n, so a rising din shows up on dout
// SYNC_STAGES clk edges later.
// Ports:
//   clk   : core clock
//   rst_n : asynchronous active-low reset, clears the chain
//   din   : asynchronous request input
//   dout  : synchronized request
// -----------------------------------------------------------------------------
module scr1_rst_sync_cell
   import scr1_rst_seq_pkg::*;
#(
   parameter int SYNC_STAGES = SCR1_RST_SEQ_SYNC_MIN
) (
   input  logic clk,
   input  logic rst_n,
   input  logic din,
   output logic dout
);

   logic [SYNC_STAGES-1:0] chain;

   // NOTE: non-blocking assignments make every stage sample the previous
   // stage's old value, giving a true shift register rather than a wire.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         chain <= '0;
      end else begin
         chain <= {chain[SYNC_STAGES-2:0], din};
      end
   end

   assign dout = chain[SYNC_STAGES-1];

endmodule

// File: rtl/scr1_reset_sequencer.sv
// -----------------------------------------------------------------------------
// scr1_reset_sequencer
// Multi-channel reset synchronizer and sequencer. Each channel synchronizes
// its request, then releases in strict order (channel 0 first) with a gap of
// RELEASE_DLY+1 cycles per channel. A channel dropping into reset pulls all
// higher channels after it, one cycle per step. test_mode drives the raw
// rst_n to every output while the FSMs keep running unseen.
// Ports:
//   clk          : core clock
//   rst_n        : asynchronous active-low reset, clears all state
//   test_mode    : 1 = every rst_n_dout bit follows rst_n
//   rst_n_din    : per-channel active-low reset requests (asynchronous)
//   rst_n_dout   : per-channel sequenced active-low resets
//   rst_n_status : per-channel release flags (1 = out of reset)
//   all_released : AND of all rst_n_status bits
// -----------------------------------------------------------------------------
module scr1_reset_sequencer
   import scr1_rst_seq_pkg::*;
#(
   parameter int N_CH        = 3,
   parameter int SYNC_STAGES = 2,
   parameter int RELEASE_DLY = 4
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            test_mode,
   input  logic [N_CH-1:0] rst_n_din,
   output logic [N_CH-1:0] rst_n_dout,
   output logic [N_CH-1:0] rst_n_status,
   output logic            all_released
);

   localparam int               CNT_W      = scr1_rst_seq_cnt_w(RELEASE_DLY);
   localparam int               CNT_LAST_I = (RELEASE_DLY == 0) ? 0 : RELEASE_DLY - 1;
   localparam logic [CNT_W-1:0] CNT_LAST   = CNT_LAST_I[CNT_W-1:0];

   logic [N_CH-1:0] req_sync;
   logic [N_CH-1:0] run;

   for (genvar i = 0; i < N_CH; i++) begin : g_ch
      logic                     en;
      logic                     dout_bit;
      logic                     status_q;
      logic [CNT_W-1:0]         cnt_q;
      type_scr1_rst_seq_state_e state_q;

      scr1_rst_sync_cell #(
         .SYNC_STAGES (SYNC_STAGES)
      ) u_sync (
         .clk   (clk),
         .rst_n (rst_n),
         .din   (rst_n_din[i]),
         .dout  (req_sync[i])
      );

      // Cascade: a channel may only run while the one below it runs.
      if (i == 0) begin : g_first
         assign en = req_sync[i];
      end else begin : g_next
         assign en = req_sync[i] & run[i-1];
      end

      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            state_q <= HOLD;
            cnt_q   <= '0;
         end else begin
            unique case (state_q)
               HOLD: begin
                  if (en) begin
                     cnt_q <= '0;
                     if (RELEASE_DLY == 0) begin
                        state_q <= RUN;
                     end else begin
                        state_q <= COUNT;
                     end
                  end
               end
               COUNT: begin
                  // An aborted count restarts from zero on the next request.
                  if (!en) begin
                     state_q <= HOLD;
                     cnt_q   <= '0;
                  end else if (cnt_q == CNT_LAST) begin
                     state_q <= RUN;
                  end else begin
                     cnt_q <= cnt_q + CNT_W'(1);
                  end
               end
               RUN: begin
                  if (!en) begin
                     state_q <= HOLD;
                  end
               end
               default: begin
                  state_q <= HOLD;
                  cnt_q   <= '0;
               end
            endcase
         end
      end

      assign run[i]   = (state_q == RUN);
      assign dout_bit = rst_n_dout[i];

      // NOTE: the status flag is cleared asynchronously by its own output
      // reset, so it drops the moment the channel re-enters reset (including
      // through test_mode or rst_n) and rises one edge after release.
      always_ff @(posedge clk or negedge dout_bit) begin
         if (!dout_bit) begin
            status_q <= 1'b0;
         end else begin
            status_q <= 1'b1;
         end
      end

      assign rst_n_status[i] = status_q;
   end

   assign rst_n_dout   = test_mode ? {N_CH{rst_n}} : run;
   assign all_released = &rst_n_status;

endmodule

// File: tb/tb_scr1_reset_sequencer.sv
// -----------------------------------------------------------------------------
// tb_scr1_reset_sequencer
// Directed vector table for the release/assert/abort/test-mode sequences of a
// 3-channel instance, a hand sequence for a 1-channel zero-delay instance,
// and a randomized phase compared against a cycle-level reference model.
// -----------------------------------------------------------------------------
module tb_scr1_reset_sequencer;

   localparam int N = 3;
   localparam int S = 2;
   localparam int D = 4;

   logic         clk;
   logic         rst_n;
   logic         test_mode;
   logic [N-1:0] din;
   logic [N-1:0] dout;
   logic [N-1:0] status;
   logic         all_rel;

   logic         rst1_n;
   logic         tm1;
   logic [0:0]   din1;
   logic [0:0]   dout1;
   logic [0:0]   status1;
   logic         all_rel1;

   int total = 0;
   int bad   = 0;

   scr1_reset_sequencer #(
      .N_CH        (N),
      .SYNC_STAGES (S),
      .RELEASE_DLY (D)
   ) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .test_mode    (test_mode),
      .rst_n_din    (din),
      .rst_n_dout   (dout),
      .rst_n_status (status),
      .all_released (all_rel)
   );

   scr1_reset_sequencer #(
      .N_CH        (1),
      .SYNC_STAGES (2),
      .RELEASE_DLY (0)
   ) dut1 (
      .clk          (clk),
      .rst_n        (rst1_n),
      .test_mode    (tm1),
      .rst_n_din    (din1),
      .rst_n_dout   (dout1),
      .rst_n_status (status1),
      .all_released (all_rel1)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // ---------------------------------------------------------------------
   // Directed vector table: apply inputs, wait n edges, compare.
   // ---------------------------------------------------------------------
   typedef struct {
      logic         rst_n;
      logic         tm;
      logic [N-1:0] din;
      int           n;
      logic [N-1:0] exp_dout;
      logic [N-1:0] exp_st;
   } vec_t;

   vec_t vecs[$];

   task automatic add(input logic r, input logic t, input logic [N-1:0] d, input int n,
                      input logic [N-1:0] ed, input logic [N-1:0] es);
      vec_t v;
      v.rst_n = r; v.tm = t; v.din = d; v.n = n; v.exp_dout = ed; v.exp_st = es;
      vecs.push_back(v);
   endtask

   // ---------------------------------------------------------------------
   // Reference model: a channel is released once its enable has been true
   // for RELEASE_DLY+1 consecutive edges; the synchronizer is a plain delay
   // line of the sampled request.
   // ---------------------------------------------------------------------
   logic [N-1:0] m_hist[S];
   int           m_streak[N];
   logic [N-1:0] m_status;

   function automatic logic [N-1:0] m_run();
      logic [N-1:0] r;
      for (int i = 0; i < N; i++) r[i] = (m_streak[i] >= D + 1);
      return r;
   endfunction

   function automatic logic [N-1:0] m_dout();
      return test_mode ? {N{rst_n}} : m_run();
   endfunction

   task automatic model_reset();
      for (int s = 0; s < S; s++) m_hist[s] = '0;
      for (int i = 0; i < N; i++) m_streak[i] = 0;
      m_status = '0;
   endtask

   task automatic model_edge();
      logic [N-1:0] old_dout;
      logic [N-1:0] old_run;
      logic [N-1:0] sync;
      logic         en;
      old_dout = m_dout();
      old_run  = m_run();
      sync     = m_hist[S-1];
      for (int i = 0; i < N; i++) begin
         if (i == 0) en = sync[0];
         else        en = sync[i] & old_run[i-1];
         if (!en)                       m_streak[i] = 0;
         else if (m_streak[i] < D + 1)  m_streak[i] = m_streak[i] + 1;
      end
      for (int s = S - 1; s > 0; s--) m_hist[s] = m_hist[s-1];
      m_hist[0] = din;
      m_status  = old_dout & m_dout();
   endtask

   initial begin
      rst_n = 1'b0; test_mode = 1'b0; din = '1;
      rst1_n = 1'b0; tm1 = 1'b0; din1 = 1'b1;

      // Release sequence from reset.
      add(0,0,3'b111,2,3'b000,3'b000);
      add(1,0,3'b111,6,3'b000,3'b000);
      add(1,0,3'b111,1,3'b001,3'b000);   // edge 7
      add(1,0,3'b111,1,3'b001,3'b001);
      add(1,0,3'b111,3,3'b001,3'b001);
      add(1,0,3'b111,1,3'b011,3'b001);   // edge 12
      add(1,0,3'b111,1,3'b011,3'b011);
      add(1,0,3'b111,4,3'b111,3'b011);   // edge 17
      add(1,0,3'b111,1,3'b111,3'b111);   // edge 18
      // Channel 1 request drop and cascade, then re-request.
      add(1,0,3'b101,2,3'b111,3'b111);
      add(1,0,3'b101,1,3'b101,3'b101);
      add(1,0,3'b101,1,3'b001,3'b001);
      add(1,0,3'b111,6,3'b001,3'b001);
      add(1,0,3'b111,1,3'b011,3'b001);
      add(1,0,3'b111,1,3'b011,3'b011);
      add(1,0,3'b111,3,3'b011,3'b011);
      add(1,0,3'b111,1,3'b111,3'b011);
      add(1,0,3'b111,1,3'b111,3'b111);
      // Abort channel 0 mid-count; full count on re-request.
      add(0,0,3'b111,1,3'b000,3'b000);
      add(1,0,3'b111,4,3'b000,3'b000);
      add(1,0,3'b110,3,3'b000,3'b000);
      add(1,0,3'b111,6,3'b000,3'b000);
      add(1,0,3'b111,1,3'b001,3'b000);
      add(1,0,3'b111,4,3'b001,3'b001);
      add(1,0,3'b111,1,3'b011,3'b001);
      // Test mode bypass.
      add(0,1,3'b000,1,3'b000,3'b000);
      add(1,1,3'b000,0,3'b111,3'b000);
      add(1,1,3'b000,1,3'b111,3'b111);
      add(0,1,3'b000,0,3'b000,3'b000);
      add(1,1,3'b000,0,3'b111,3'b000);
      add(1,0,3'b000,1,3'b000,3'b000);

      for (int k = 0; k < vecs.size(); k++) begin
         rst_n     = vecs[k].rst_n;
         test_mode = vecs[k].tm;
         din       = vecs[k].din;
         if (vecs[k].n == 0) begin
            #1;
         end else begin
            repeat (vecs[k].n) @(posedge clk);
            @(negedge clk);
         end
         check($sformatf("vec%0d_dout", k), 16'(dout), 16'(vecs[k].exp_dout));
         check($sformatf("vec%0d_status", k), 16'(status), 16'(vecs[k].exp_st));
         check($sformatf("vec%0d_all", k), 16'(all_rel), 16'(&vecs[k].exp_st));
      end

      // Single channel, zero delay: release at edge 3, async assertion.
      @(negedge clk);
      check("n1_reset_dout", 16'(dout1), 16'h0);
      rst1_n = 1'b1;
      repeat (2) @(posedge clk);
      @(negedge clk);
      check("n1_edge2_dout", 16'(dout1), 16'h0);
      @(posedge clk);
      @(negedge clk);
      check("n1_edge3_dout", 16'(dout1), 16'h1);
      check("n1_edge3_status", 16'(status1), 16'h0);
      @(posedge clk);
      @(negedge clk);
      check("n1_edge4_status", 16'(status1), 16'h1);
      check("n1_edge4_all", 16'(all_rel1), 16'h1);
      #2 rst1_n = 1'b0;
      #1;
      check("n1_async_dout", 16'(dout1), 16'h0);
      check("n1_async_status", 16'(status1), 16'h0);
      check("n1_async_all", 16'(all_rel1), 16'h0);

      // Randomized phase against the reference model.
      @(negedge clk);
      rst_n = 1'b0; test_mode = 1'b0; din = '1;
      model_reset();
      @(negedge clk);
      for (int k = 0; k < 800; k++) begin
         rst_n     = ($urandom_range(0, 199) != 0);
         test_mode = ($urandom_range(0, 19) == 0);
         for (int b = 0; b < N; b++) begin
            if (din[b]) din[b] = ($urandom_range(0, 39) != 0);
            else        din[b] = ($urandom_range(0, 3) == 0);
         end
         if (!rst_n) model_reset();
         else        m_status = m_status & m_dout();
         @(posedge clk);
         if (rst_n) model_edge();
         @(negedge clk);
         check($sformatf("rnd%0d_dout", k), 16'(dout), 16'(m_dout()));
         check($sformatf("rnd%0d_status", k), 16'(status), 16'(m_status));
         check($sformatf("rnd%0d_all", k), 16'(all_rel), 16'(&m_status));
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
